// File: rtl/mux2_flit.sv
// Registered 2-to-1 flit multiplexer: forwards {data, valid, vch} of the port
// picked by a one-hot select, with exactly one cycle of latency.
module mux2_flit #(
    parameter int DATA_W = 64,
    parameter int VCH_W  = 2,
    parameter int SEL_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] idata_0,
    input  logic              ivalid_0,
    input  logic [VCH_W-1:0]  ivch_0,
    input  logic [DATA_W-1:0] idata_1,
    input  logic              ivalid_1,
    input  logic [VCH_W-1:0]  ivch_1,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] odata,
    output logic              ovalid,
    output logic [VCH_W-1:0]  ovch
);

    // Valid semantics: ovalid is a plain copy of the selected ivalid; there is
    // no ready/backpressure, so every selected flit is forwarded the next cycle.

    logic [DATA_W-1:0] odata_q, odata_d;
    logic              ovalid_q, ovalid_d;
    logic [VCH_W-1:0]  ovch_q, ovch_d;

    always_comb begin
        odata_d  = '0;
        ovalid_d = 1'b0;
        ovch_d   = '0;
        // Port 0 wins when both low select bits are set.
        if (sel[0]) begin
            odata_d  = idata_0;
            ovalid_d = ivalid_0;
            ovch_d   = ivch_0;
        end else if (sel[1]) begin
            odata_d  = idata_1;
            ovalid_d = ivalid_1;
            ovch_d   = ivch_1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            ovch_q   <= '0;
        end else begin
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            ovch_q   <= ovch_d;
        end
    end

    // Upper select bits belong to the router's wider port encoding and are ignored here.
    generate
        if (SEL_W > 2) begin : g_sel_hi
            logic unused_sel_hi;
            assign unused_sel_hi = ^sel[SEL_W-1:2];
        end
    endgenerate

    assign odata  = odata_q;
    assign ovalid = ovalid_q;
    assign ovch   = ovch_q;

endmodule

// File: tb/tb_mux2_flit.sv
// Bench for mux2_flit: a reference model predicts each output word when inputs
// are driven; the prediction is queued and compared one clock edge later.
module tb_mux2_flit;

    localparam int DATA_W = 64;
    localparam int VCH_W  = 2;
    localparam int SEL_W  = 5;
    localparam int W      = DATA_W + 1 + VCH_W;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] idata_0, idata_1;
    logic              ivalid_0, ivalid_1;
    logic [VCH_W-1:0]  ivch_0, ivch_1;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] odata;
    logic              ovalid;
    logic [VCH_W-1:0]  ovch;

    logic [W-1:0] exp_q[$];
    int checks_total;
    int checks_passed;

    mux2_flit #(.DATA_W(DATA_W), .VCH_W(VCH_W), .SEL_W(SEL_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .idata_0  (idata_0),
        .ivalid_0 (ivalid_0),
        .ivch_0   (ivch_0),
        .idata_1  (idata_1),
        .ivalid_1 (ivalid_1),
        .ivch_1   (ivch_1),
        .sel      (sel),
        .odata    (odata),
        .ovalid   (ovalid),
        .ovch     (ovch)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks_total++;
        if (obs === exp) checks_passed++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] model();
        if (rst)         return '0;
        else if (sel[0]) return {idata_0, ivalid_0, ivch_0};
        else if (sel[1]) return {idata_1, ivalid_1, ivch_1};
        else             return '0;
    endfunction

    task automatic set_in(input logic r, input logic [SEL_W-1:0] s,
                          input logic [DATA_W-1:0] d0, input logic v0, input logic [VCH_W-1:0] c0,
                          input logic [DATA_W-1:0] d1, input logic v1, input logic [VCH_W-1:0] c1);
        rst = r; sel = s;
        idata_0 = d0; ivalid_0 = v0; ivch_0 = c0;
        idata_1 = d1; ivalid_1 = v1; ivch_1 = c1;
    endtask

    // Predict, clock once, then compare the registered outputs.
    task automatic step(input string tag);
        logic [W-1:0] exp;
        logic [W-1:0] obs;
        exp_q.push_back(model());
        @(posedge clk);
        #1;
        obs = {odata, ovalid, ovch};
        exp = exp_q.pop_front();
        check_val(tag, obs, exp);
    endtask

    function automatic logic [DATA_W-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    logic [DATA_W-1:0] pats[3];
    logic [DATA_W-1:0] d;

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        pats[0] = 64'h0;
        pats[1] = 64'h0007_FFFF_F800_0000;
        pats[2] = 64'h0007_FFFF_FFFF_FFF8;

        // Reset with both ports valid: outputs must stay zero.
        set_in(1'b1, 5'b00010, 64'h1111_2222_3333_4444, 1'b1, 2'd1,
                               64'h5555_6666_7777_8888, 1'b1, 2'd3);
        @(negedge clk);
        step("reset_0");
        check_val("reset_zero_0", {odata, ovalid, ovch}, '0);
        step("reset_1");
        check_val("reset_zero_1", {odata, ovalid, ovch}, '0);
        rst = 1'b0;
        step("first_after_reset");
        check_val("first_port1", {odata, ovalid, ovch}, {64'h5555_6666_7777_8888, 1'b1, 2'd3});

        // Port 1 packet while port 0 carries random valid traffic.
        set_in(1'b0, 5'b00010, rnd64(), 1'b1, 2'($urandom_range(0, 3)),
                               64'h4000_0000_0000_0004, 1'b1, 2'd1);
        step("p1_head");
        for (int i = 0; i < 20; i++) begin
            set_in(1'b0, 5'b00010, rnd64(), 1'b1, 2'($urandom_range(0, 3)),
                                   pats[i % 3], 1'b1, 2'd1);
            step("p1_data");
        end
        set_in(1'b0, 5'b00010, rnd64(), 1'b1, 2'($urandom_range(0, 3)),
                               64'hC000_0000_0000_00FF, 1'b1, 2'd1);
        step("p1_tail");
        check_val("p1_tail_abs", {odata, ovalid, ovch}, {64'hC000_0000_0000_00FF, 1'b1, 2'd1});

        // Port 0 select.
        set_in(1'b0, 5'b00001, 64'h0123_4567_89AB_CDEF, 1'b1, 2'd2, rnd64(), 1'b1, 2'd1);
        step("p0_sel");
        check_val("p0_sel_abs", {odata, ovalid, ovch}, {64'h0123_4567_89AB_CDEF, 1'b1, 2'd2});

        // Priority and no-select.
        set_in(1'b0, 5'b00011, 64'hDEAD_BEEF_0000_0001, 1'b1, 2'd0, 64'hFFFF_0000_FFFF_0000, 1'b1, 2'd3);
        step("prio_p0");
        check_val("prio_abs", {odata, ovalid, ovch}, {64'hDEAD_BEEF_0000_0001, 1'b1, 2'd0});
        set_in(1'b0, 5'b11100, rnd64(), 1'b1, 2'd3, rnd64(), 1'b1, 2'd3);
        step("no_sel");
        check_val("no_sel_abs", {odata, ovalid, ovch}, '0);

        // Data forwarded even when the selected port is not valid.
        set_in(1'b0, 5'b00010, rnd64(), 1'b1, 2'd1, 64'hAAAA, 1'b0, 2'd2);
        step("invalid_fwd");
        check_val("invalid_abs", {odata, ovalid, ovch}, {64'hAAAA, 1'b0, 2'd2});

        // Alternate ports every cycle, with a one-cycle reset mid-packet.
        for (int i = 0; i < 10; i++) begin
            d = 64'h1000 + 64'(i);
            set_in(i == 5, (i % 2 == 0) ? 5'b00001 : 5'b00010,
                   d, 1'b1, 2'(i), ~d, 1'b1, 2'(i + 1));
            step(i == 5 ? "toggle_rst" : "toggle");
        end

        // Random mix of selects, validity and occasional reset.
        for (int i = 0; i < 60; i++) begin
            set_in($urandom_range(0, 15) == 0, 5'($urandom_range(0, 31)),
                   rnd64(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   rnd64(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            step("random");
        end

        check_val("queue_drained", W'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/mux2_flit.md
Name: mux2_flit

Overview:
- Registered 2-to-1 flit multiplexer for the NoC router datapath.
- Forwards the data, valid and virtual-channel fields of one of two input ports to a single output port.
- Port selection uses a one-hot select vector sized for the router's 5-port encoding.
- Used standalone for switching-energy characterization and inside the router crossbar.

Parameters:
- DATA_W, 64: flit width in bits (type field plus payload).
- VCH_W, 2: virtual-channel id width.
- SEL_W, 5: one-hot select width; bits 0 and 1 map to inputs 0 and 1, all higher bits are ignored.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- idata_0  input  DATA_W  flit data, input port 0.
- ivalid_0  input  1  flit valid, input port 0.
- ivch_0  input  VCH_W  virtual channel, input port 0.
- idata_1  input  DATA_W  flit data, input port 1.
- ivalid_1  input  1  flit valid, input port 1.
- ivch_1  input  VCH_W  virtual channel, input port 1.
- sel  input  SEL_W  one-hot port select.
- odata  output  DATA_W  registered selected flit data.
- ovalid  output  1  registered selected valid.
- ovch  output  VCH_W  registered selected virtual channel.

Behaviour:
- One clock domain; rst is synchronous and active-high.
- Reset: on a rising clk with rst=1, odata=0, ovalid=0 and ovch=0. All input values are ignored that cycle.
- Reset applied mid-packet clears the outputs on the next edge. No partial flit is held.
- Latency is exactly 1 cycle: the outputs after edge k reflect the inputs and sel sampled at edge k.
- Selection is evaluated every cycle with no state beyond the output register:
  - sel[0]=1: output takes {idata_0, ivalid_0, ivch_0}. Port 0 has priority when sel[0] and sel[1] are both set.
  - sel[0]=0, sel[1]=1: output takes {idata_1, ivalid_1, ivch_1}.
  - sel[1:0]=00: odata=0, ovalid=0, ovch=0. Bits sel[SEL_W-1:2] never affect the result.
- Data and vch are forwarded from the selected port regardless of its ivalid. ovalid is a copy of the selected ivalid.
- The unselected port has no effect on any output, even when it is valid.
- No flow control and no backpressure: the block never stalls and never drops a selected flit.
- A flit is passed through unmodified, including its type field (head/data/tail/none) in the MSBs. No width conversion, and no truncation when widths match the parameters.
- sel may change on any cycle. The new selection takes effect on the flit sampled at that same edge, with no bubble and no hold.
- Back-to-back flits on the selected port appear back-to-back on the output with a constant 1-cycle offset.

Test Plan:
- Reset: hold rst=1 for 2 cycles with both ports valid and sel=5'b00010 -> odata=0, ovalid=0, ovch=0 after each edge. First edge after rst=0 shows port 1.
- Port 1 stream: sel=5'b00010; port 1 sends head 0x...04, then 20 data flits cycling through the bit patterns 0x0, 0x7FFFFF8000000, 0x7FFFFFFFFFFF8, then a tail -> odata equals each idata_1 one cycle later with ovalid=1. Port 0 random traffic never appears.
- Port 0 select: sel=5'b00001, idata_0=0x0123456789ABCDEF, ivalid_0=1, ivch_0=2 -> next cycle odata=0x0123456789ABCDEF, ovalid=1, ovch=2.
- Priority and no-select: sel=5'b00011 -> port 0 forwarded. sel=5'b11100 -> odata=0, ovalid=0, ovch=0.
- Invalid forwarding: sel=5'b00010, ivalid_1=0, idata_1=0xAAAA -> odata=0xAAAA, ovalid=0.
- Mid-stream switch and reset: toggle sel between ports every cycle -> output alternates with 1-cycle lag, no gaps. Assert rst for one cycle mid-packet -> zeros for exactly one cycle, then resumes forwarding.
